pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register for the MIPS pipeline: the successor to the fixed-field, clear-only stage registers. It carries an opaque packed payload of `DATA_W` bits between two pipeline stages using a valid/ready handshake. An optional 2-entry skid buffer breaks the combinational ready path. It also provides a synchronous flush for branch/exception squash and a saturating back-pressure counter for performance debug.

## Interface
Parameters:
- `DATA_W`, 128: payload width in bits (≥1); the concatenated control and data fields of a stage.
- `SKID`, 1: 1 = 2-entry skid buffer with registered `up_ready_o`; 0 = single entry with combinational `up_ready_o`.
- `CLR_DATA`, 1: 1 = payload registers zeroed on reset/flush; 0 = only valid state cleared.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous squash of all held entries.
- `up_valid_i` in 1: upstream beat present.
- `up_ready_o` out 1: stage accepts a beat this cycle.
- `up_data_i` in `DATA_W`: upstream payload.
- `dn_valid_o` out 1: downstream beat present.
- `dn_ready_i` in 1: downstream consumes the beat this cycle.
- `dn_data_o` out `DATA_W`: downstream payload (main entry).
- `stall_cnt_o` out 16: saturating count of back-pressured cycles.

## Operation
- Accept = `up_valid_i && up_ready_o`. Consume = `dn_valid_o && dn_ready_i`. Strict FIFO order, no duplication, no loss except by flush.
- State (SKID=1): EMPTY, ONE (main valid), FULL (main and skid valid).
  - EMPTY: accept → ONE, with data into main.
  - ONE: accept only → FULL, with data into skid. Consume only → EMPTY. Accept and consume together → ONE, main reloaded.
  - FULL: consume → ONE, skid moves to main. No accept is possible.
- `up_ready_o` (SKID=1) = state != FULL, driven from a flop.
- SKID=0: states EMPTY/ONE only; `up_ready_o = !dn_valid_o || dn_ready_i` (combinational).
- `dn_valid_o` = state != EMPTY. `dn_data_o` = main entry, held stable while `dn_valid_o && !dn_ready_i`.
- Priority: `reset` > `flush` > handshake.
- `flush`:
  - Next state EMPTY. A beat offered in the flush cycle is dropped, and a beat presented downstream in the flush cycle still counts as consumed if `dn_ready_i`.
  - Payload is zeroed if CLR_DATA=1.
  - `stall_cnt_o` is unaffected.
- `stall_cnt_o`: +1 on each cycle with `dn_valid_o && !dn_ready_i`, saturating at 16'hFFFF. Cleared by `reset` only.

## Timing
- Reset values: `dn_valid_o`=0, `dn_data_o`=0 (X allowed if CLR_DATA=0), `stall_cnt_o`=0, internal state EMPTY.
  - `up_ready_o`=1 from the first cycle after reset deassertion.
  - Inputs are ignored during any cycle with `reset`=1.
- Latency: a beat accepted at edge N appears on `dn_*` after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained when `dn_ready_i`=1.
- SKID=1: after `dn_ready_i` deasserts, the stage absorbs exactly one more beat, then `up_ready_o`=0 from the next cycle. `up_ready_o` returns to 1 the cycle after the first consume.
- Reset or flush mid-stall: state is EMPTY the next cycle; the skid content is discarded.
- Flush and accept in the same cycle: the accepted beat is discarded (upstream sees its handshake complete).

## Structure
- Shared package `pipe_pkg`:
  - state encoding `pipe_state_t` (EMPTY=2'b00, ONE=2'b01, FULL=2'b10);
  - constant `PIPE_STALL_CNT_W`=16.
- Sub-module `pipe_sat_cnt` (width-parametrised saturating counter with sync clear and increment enable) implements `stall_cnt_o`.
- The SKID=0/1 variants are generate branches within one module.

## Test plan
- Reset then stream: `dn_ready_i`=1, 8 beats 0x1..0x8 back-to-back → `dn_data_o` shows 0x1..0x8 on consecutive cycles, 1-cycle latency, `up_ready_o` constantly 1.
- Back-pressure (SKID=1): hold `dn_ready_i`=0 while offering 0xA, 0xB, 0xC → 0xA and 0xB accepted, `up_ready_o`=0 after 0xB. Release → 0xA, 0xB, 0xC delivered in order. `stall_cnt_o` equals the number of stalled cycles.
- Flush in FULL: held 0xA/0xB, assert `flush` with `up_valid_i`=1 offering 0xD → next cycle `dn_valid_o`=0, `dn_data_o`=0, 0xD never delivered. `stall_cnt_o` is unchanged.
- SKID=0 pass-through: `dn_ready_i` toggles 1/0 each cycle → `up_ready_o` follows `!dn_valid_o || dn_ready_i` in the same cycle; no beat is lost or duplicated.
- Counter saturation: stall for 70000 cycles → `stall_cnt_o` sticks at 16'hFFFF; `reset` → 0.
- Reset mid-stall: FULL state, assert `reset` for 1 cycle → `dn_valid_o`=0 and `up_ready_o`=1 on the following cycle; a new beat 0x55 is delivered normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the pipeline stage registers.
//   pipe_state_t     : occupancy of a stage (EMPTY / ONE / FULL)
//   PIPE_STALL_CNT_W : width of the back-pressure debug counter
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,  // nothing held
    ONE   = 2'b01,  // main entry valid
    FULL  = 2'b10   // main and skid entries valid
  } pipe_state_t;

  localparam int PIPE_STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_sat_cnt.sv
// pipe_sat_cnt: width-parametrised saturating up-counter.
//   clk : clock, rising edge
//   clr : synchronous clear (wins over inc)
//   inc : count enable; the count sticks at all-ones
//   cnt : current count
module pipe_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional
// 2-entry skid buffer, synchronous flush and a saturating stall counter.
//   clk, reset             : clock and synchronous active-high reset
//   flush                  : squash all held entries (reset has priority)
//   up_valid_i/up_ready_o  : upstream handshake, up_data_i payload
//   dn_valid_o/dn_ready_i  : downstream handshake, dn_data_o payload
//   stall_cnt_o            : cycles with dn_valid_o && !dn_ready_i
// SKID=1 registers up_ready_o (2 entries); SKID=0 uses one entry and a
// combinational up_ready_o.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        up_valid_i,
  output logic                        up_ready_o,
  input  logic [DATA_W-1:0]           up_data_i,
  output logic                        dn_valid_o,
  input  logic                        dn_ready_i,
  output logic [DATA_W-1:0]           dn_data_o,
  output logic [PIPE_STALL_CNT_W-1:0] stall_cnt_o
);

  pipe_state_t       state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              accept, consume;

  assign accept  = up_valid_i && up_ready_o;
  assign consume = dn_valid_o && dn_ready_i;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Main entry; with CLR_DATA=0 reset leaves the payload untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLR_DATA != 0) begin
        main_reg <= '0;
      end
    end else begin
      main_reg <= main_next;
    end
  end

  // Next-state and payload steering
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    if (flush) begin
      // A beat accepted in this cycle is dropped along with held ones.
      state_next = EMPTY;
      if (CLR_DATA != 0) begin
        main_next = '0;
        skid_next = '0;
      end
    end else begin
      unique case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next = ONE;
            main_next  = up_data_i;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_next = up_data_i;
          end else if (accept) begin
            // Only reachable with SKID=1: SKID=0 is not ready here.
            state_next = FULL;
            skid_next  = up_data_i;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_next = ONE;
            main_next  = skid_reg;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic up_ready_reg;

      // Ready is known one cycle ahead from the next occupancy, so the
      // upstream ready path never sees dn_ready_i combinationally.
      always_ff @(posedge clk) begin
        if (reset) begin
          up_ready_reg <= 1'b1;
        end else begin
          up_ready_reg <= (state_next != FULL);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          if (CLR_DATA != 0) begin
            skid_reg <= '0;
          end
        end else begin
          skid_reg <= skid_next;
        end
      end

      assign up_ready_o = up_ready_reg;
    end else begin : g_noskid
      assign skid_reg   = '0;
      assign up_ready_o = !dn_valid_o || dn_ready_i;
    end
  endgenerate

  // Outputs
  always_comb begin
    dn_valid_o = (state_reg != EMPTY);
    dn_data_o  = main_reg;
  end

  pipe_sat_cnt #(
    .W(PIPE_STALL_CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(reset),
    .inc(dn_valid_o && !dn_ready_i),
    .cnt(stall_cnt_o)
  );

endmodule
